// File: rtl/uart_rx_pkt_ctrl_if.sv
// Bundle of the receiver-side and downstream-side signals of the UART packet controller.
// The controller connects through the slave modport; the receiver/consumer side uses master.
interface uart_rx_pkt_ctrl_if;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       rx_error;
  logic       rx_enable;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_last;
  logic       out_ready;
  logic       pkt_err;
  logic [1:0] err_code;
  logic [7:0] err_cnt;

  modport master (
    output rx_data, rx_done, rx_error, out_ready,
    input  rx_enable, out_data, out_valid, out_last, pkt_err, err_code, err_cnt
  );

  modport slave (
    input  rx_data, rx_done, rx_error, out_ready,
    output rx_enable, out_data, out_valid, out_last, pkt_err, err_code, err_cnt
  );
endinterface

// File: rtl/uart_rx_pkt_ctrl.sv
// Sequences a UART byte receiver and frames its bytes as HEADER, LEN, payload, CHK packets.
// The payload is buffered and only released downstream once its XOR checksum matches.
module uart_rx_pkt_ctrl #(
  parameter logic [7:0] HEADER      = 8'hA5,
  parameter int         MAX_LEN     = 16,
  parameter int         TIMEOUT_CYC = 50_000
) (
  input  logic              clk,
  input  logic              rst,
  uart_rx_pkt_ctrl_if.slave bus
);
  localparam int         IW        = $clog2(MAX_LEN + 1);
  localparam int         AW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int         TW        = $clog2(TIMEOUT_CYC);
  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  typedef enum logic [2:0] {
    HUNT  = 3'd0,
    LEN   = 3'd1,
    PAY   = 3'd2,
    CHK   = 3'd3,
    DRAIN = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    ERR_PARITY  = 2'd0,
    ERR_LENGTH  = 2'd1,
    ERR_CHKSUM  = 2'd2,
    ERR_TIMEOUT = 2'd3
  } err_t;

  state_t        state, state_next;
  logic          rx_done_d, armed, byte_evt;
  logic [IW-1:0] len, idx, rd_idx;
  logic [7:0]    chk;
  logic [TW-1:0] timer;
  logic          timer_hit, xfer, last_beat;
  logic          abort, take_len, take_pay, start_drain;
  err_t          abort_code;
  logic          rx_enable_q, pkt_err_q;
  logic [1:0]    err_code_q;
  logic [7:0]    err_cnt_q;
  logic [7:0]    pay_buf [MAX_LEN];

  // A byte counts only on an rx_done rise that followed a fall we actually saw.
  assign byte_evt  = bus.rx_done & ~rx_done_d & armed;
  assign timer_hit = (timer == TW'(TIMEOUT_CYC - 1));
  assign last_beat = (rd_idx == len - 1'b1);
  assign xfer      = (state == DRAIN) & bus.out_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= HUNT;
    else     state <= state_next;
  end

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    state_next  = state;
    abort       = 1'b0;
    abort_code  = ERR_PARITY;
    take_len    = 1'b0;
    take_pay    = 1'b0;
    start_drain = 1'b0;
    unique case (state)
      HUNT: begin
        if (byte_evt && bus.rx_data == HEADER && !bus.rx_error) state_next = LEN;
      end
      LEN: begin
        if (byte_evt) begin
          if (bus.rx_error) begin
            abort = 1'b1;
          end else if (bus.rx_data == 8'd0 || bus.rx_data > MAX_LEN_B) begin
            abort      = 1'b1;
            abort_code = ERR_LENGTH;
          end else begin
            take_len   = 1'b1;
            state_next = PAY;
          end
        end else if (timer_hit) begin
          abort      = 1'b1;
          abort_code = ERR_TIMEOUT;
        end
      end
      PAY: begin
        if (byte_evt) begin
          if (bus.rx_error) begin
            abort = 1'b1;
          end else begin
            take_pay = 1'b1;
            if (idx == len - 1'b1) state_next = CHK;
          end
        end else if (timer_hit) begin
          abort      = 1'b1;
          abort_code = ERR_TIMEOUT;
        end
      end
      CHK: begin
        if (byte_evt) begin
          if (bus.rx_error) begin
            abort = 1'b1;
          end else if (bus.rx_data == chk) begin
            start_drain = 1'b1;
            state_next  = DRAIN;
          end else begin
            abort      = 1'b1;
            abort_code = ERR_CHKSUM;
          end
        end else if (timer_hit) begin
          abort      = 1'b1;
          abort_code = ERR_TIMEOUT;
        end
      end
      DRAIN: begin
        // Any byte event here belongs to a byte already in flight and is dropped.
        if (xfer && last_beat) state_next = HUNT;
      end
      default: state_next = HUNT;
    endcase
    if (abort) state_next = HUNT;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_done_d   <= 1'b1;
      armed       <= 1'b0;
      len         <= '0;
      idx         <= '0;
      rd_idx      <= '0;
      chk         <= 8'h00;
      timer       <= '0;
      rx_enable_q <= 1'b0;
      pkt_err_q   <= 1'b0;
      err_code_q  <= 2'd0;
      err_cnt_q   <= 8'h00;
    end else begin
      rx_done_d <= bus.rx_done;
      if (byte_evt)                        armed <= 1'b0;
      else if (!bus.rx_done && rx_done_d)  armed <= 1'b1;

      if (take_len) begin
        len <= bus.rx_data[IW-1:0];
        chk <= bus.rx_data;
        idx <= '0;
      end else if (take_pay) begin
        chk <= chk ^ bus.rx_data;
        idx <= idx + 1'b1;
      end

      if (start_drain) rd_idx <= '0;
      else if (xfer)   rd_idx <= rd_idx + 1'b1;

      // The inter-byte timer restarts on any state change and on every byte.
      if (byte_evt || state_next != state)          timer <= '0;
      else if (state == LEN || state == PAY || state == CHK) timer <= timer + 1'b1;

      rx_enable_q <= (state_next != DRAIN);
      pkt_err_q   <= abort;
      if (abort) begin
        err_code_q <= abort_code;
        if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
      end
    end
  end

  // NOTE: the payload buffer is plain storage with no reset; its contents are never read before being written.
  always_ff @(posedge clk) begin
    if (take_pay) pay_buf[idx[AW-1:0]] <= bus.rx_data;
  end

  assign bus.rx_enable = rx_enable_q;
  assign bus.out_valid = (state == DRAIN);
  assign bus.out_data  = (state == DRAIN) ? pay_buf[rd_idx[AW-1:0]] : 8'h00;
  assign bus.out_last  = (state == DRAIN) & last_beat;
  assign bus.pkt_err   = pkt_err_q;
  assign bus.err_code  = err_code_q;
  assign bus.err_cnt   = err_cnt_q;
endmodule

// File: tb/tb_uart_rx_pkt_ctrl.sv
// Directed-vector bench for uart_rx_pkt_ctrl: framing, checksum, length, timeout, stall and reset cases.
// A small receiver model drives rx_done low, then presents the byte and raises rx_done.
module tb_uart_rx_pkt_ctrl;
  localparam int MAX_LEN     = 16;
  localparam int TIMEOUT_CYC = 200;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_rx_pkt_ctrl_if bus_if ();

  uart_rx_pkt_ctrl #(
    .HEADER      (8'hA5),
    .MAX_LEN     (MAX_LEN),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave)
  );

  int         checks = 0;
  int         errors = 0;
  int         pulse_cnt = 0;
  logic [7:0] cap_data [64];
  logic       cap_last [64];
  int         cap_n;

  always @(negedge clk) if (bus_if.pkt_err === 1'b1) pulse_cnt++;

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus_if.rx_done   = 1'b1;
    bus_if.rx_error  = 1'b0;
    bus_if.rx_data   = 8'h00;
    bus_if.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Returns at the falling edge right after the clk edge that processes the byte.
  task automatic send_byte(input logic [7:0] b, input logic err = 1'b0);
    bus_if.rx_done = 1'b0;
    repeat (3) @(negedge clk);
    bus_if.rx_data  = b;
    bus_if.rx_error = err;
    bus_if.rx_done  = 1'b1;
    @(negedge clk);
    bus_if.rx_error = 1'b0;
  endtask

  // Captures one beat per falling edge while out_valid is high, with out_ready held at 1.
  task automatic collect_burst();
    cap_n = 0;
    bus_if.out_ready = 1'b1;
    while (bus_if.out_valid === 1'b1 && cap_n < 40) begin
      cap_data[cap_n] = bus_if.out_data;
      cap_last[cap_n] = bus_if.out_last;
      cap_n++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    bus_if.rx_done = 1'b1; bus_if.rx_error = 1'b0; bus_if.rx_data = 8'h00; bus_if.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (bus_if.rx_enable !== 1'b0) begin errors++; $display("FAIL reset_rx_enable got=%b exp=0", bus_if.rx_enable); end
    checks++; if (bus_if.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", bus_if.out_valid); end
    checks++; if (bus_if.out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data got=%h exp=00", bus_if.out_data); end
    checks++; if (bus_if.out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last got=%b exp=0", bus_if.out_last); end
    checks++; if (bus_if.pkt_err !== 1'b0) begin errors++; $display("FAIL reset_pkt_err got=%b exp=0", bus_if.pkt_err); end
    checks++; if (bus_if.err_code !== 2'd0) begin errors++; $display("FAIL reset_err_code got=%0d exp=0", bus_if.err_code); end
    checks++; if (bus_if.err_cnt !== 8'd0) begin errors++; $display("FAIL reset_err_cnt got=%0d exp=0", bus_if.err_cnt); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (bus_if.rx_enable !== 1'b1) begin errors++; $display("FAIL post_reset_rx_enable got=%b exp=1", bus_if.rx_enable); end
  endtask

  task automatic test_basic();
    logic [7:0] exp [3] = '{8'h11, 8'h22, 8'h33};
    int p0;
    do_reset();
    p0 = pulse_cnt;
    send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    send_byte(8'h03);
    collect_burst();
    checks++; if (cap_n !== 3) begin errors++; $display("FAIL basic_beats got=%0d exp=3", cap_n); end
    for (int i = 0; i < 3 && i < cap_n; i++) begin
      checks++; if (cap_data[i] !== exp[i]) begin errors++; $display("FAIL basic_data[%0d] got=%h exp=%h", i, cap_data[i], exp[i]); end
      checks++; if (cap_last[i] !== (i == 2)) begin errors++; $display("FAIL basic_last[%0d] got=%b exp=%b", i, cap_last[i], (i == 2)); end
    end
    @(negedge clk);
    checks++; if (pulse_cnt !== p0) begin errors++; $display("FAIL basic_no_pkt_err got=%0d exp=%0d", pulse_cnt, p0); end
  endtask

  task automatic test_checksum();
    do_reset();
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h10); send_byte(8'h20);
    send_byte(8'hFF);
    checks++; if (bus_if.pkt_err !== 1'b1) begin errors++; $display("FAIL chk_pkt_err got=%b exp=1", bus_if.pkt_err); end
    checks++; if (bus_if.err_code !== 2'd2) begin errors++; $display("FAIL chk_err_code got=%0d exp=2", bus_if.err_code); end
    checks++; if (bus_if.err_cnt !== 8'd1) begin errors++; $display("FAIL chk_err_cnt got=%0d exp=1", bus_if.err_cnt); end
    checks++; if (bus_if.out_valid !== 1'b0) begin errors++; $display("FAIL chk_out_valid got=%b exp=0", bus_if.out_valid); end
    @(negedge clk);
    checks++; if (bus_if.pkt_err !== 1'b0) begin errors++; $display("FAIL chk_pkt_err_width got=%b exp=0", bus_if.pkt_err); end
    checks++; if (bus_if.out_valid !== 1'b0) begin errors++; $display("FAIL chk_no_output got=%b exp=0", bus_if.out_valid); end
  endtask

  task automatic test_bad_len();
    do_reset();
    send_byte(8'hA5); send_byte(8'h00);
    checks++; if (bus_if.pkt_err !== 1'b1) begin errors++; $display("FAIL len0_pkt_err got=%b exp=1", bus_if.pkt_err); end
    checks++; if (bus_if.err_code !== 2'd1) begin errors++; $display("FAIL len0_err_code got=%0d exp=1", bus_if.err_code); end
    send_byte(8'hA5); send_byte(8'h11);
    checks++; if (bus_if.err_code !== 2'd1) begin errors++; $display("FAIL len17_err_code got=%0d exp=1", bus_if.err_code); end
    checks++; if (bus_if.err_cnt !== 8'd2) begin errors++; $display("FAIL len_err_cnt got=%0d exp=2", bus_if.err_cnt); end
    // Full MAX_LEN packet: payload 0..15, XOR of 0..15 is 0, so chk = 0x10.
    send_byte(8'hA5); send_byte(8'h10);
    for (int i = 0; i < 16; i++) send_byte(8'(i));
    send_byte(8'h10);
    collect_burst();
    checks++; if (cap_n !== 16) begin errors++; $display("FAIL maxlen_beats got=%0d exp=16", cap_n); end
    for (int i = 0; i < 16 && i < cap_n; i++) begin
      checks++; if (cap_data[i] !== 8'(i)) begin errors++; $display("FAIL maxlen_data[%0d] got=%h exp=%h", i, cap_data[i], 8'(i)); end
    end
    checks++; if (cap_n > 0 && cap_last[cap_n-1] !== 1'b1) begin errors++; $display("FAIL maxlen_last got=%b exp=1", cap_last[cap_n-1]); end
    checks++; if (bus_if.err_cnt !== 8'd2) begin errors++; $display("FAIL maxlen_err_cnt got=%0d exp=2", bus_if.err_cnt); end
  endtask

  task automatic test_timeout();
    do_reset();
    send_byte(8'hA5); send_byte(8'h04); send_byte(8'h01);
    repeat (TIMEOUT_CYC - 1) @(negedge clk);
    checks++; if (bus_if.pkt_err !== 1'b0) begin errors++; $display("FAIL timeout_early got=%b exp=0", bus_if.pkt_err); end
    @(negedge clk);
    checks++; if (bus_if.pkt_err !== 1'b1) begin errors++; $display("FAIL timeout_pkt_err got=%b exp=1", bus_if.pkt_err); end
    checks++; if (bus_if.err_code !== 2'd3) begin errors++; $display("FAIL timeout_err_code got=%0d exp=3", bus_if.err_code); end
    checks++; if (bus_if.err_cnt !== 8'd1) begin errors++; $display("FAIL timeout_err_cnt got=%0d exp=1", bus_if.err_cnt); end
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'hC3); send_byte(8'hC2);
    collect_burst();
    checks++; if (cap_n !== 1 || cap_data[0] !== 8'hC3) begin errors++; $display("FAIL timeout_recover got_n=%0d got=%h exp=c3", cap_n, cap_data[0]); end
  endtask

  task automatic test_stall();
    int k;
    int c;
    do_reset();
    send_byte(8'hA5); send_byte(8'h04); send_byte(8'hD1); send_byte(8'hD2); send_byte(8'hD3); send_byte(8'hD4);
    send_byte(8'h00);
    k = 0;
    c = 0;
    while (k < 4 && c < 40) begin
      checks++; if (bus_if.out_valid !== 1'b1) begin errors++; $display("FAIL stall_valid[%0d] got=%b exp=1", c, bus_if.out_valid); end
      checks++; if (bus_if.out_data !== 8'(8'hD1 + k)) begin errors++; $display("FAIL stall_data[%0d] got=%h exp=%h", c, bus_if.out_data, 8'(8'hD1 + k)); end
      checks++; if (bus_if.out_last !== (k == 3)) begin errors++; $display("FAIL stall_last[%0d] got=%b exp=%b", c, bus_if.out_last, (k == 3)); end
      checks++; if (bus_if.rx_enable !== 1'b0) begin errors++; $display("FAIL stall_rx_enable[%0d] got=%b exp=0", c, bus_if.rx_enable); end
      bus_if.out_ready = (c % 3 == 0);
      @(negedge clk);
      if (bus_if.out_ready) k++;
      c++;
    end
    bus_if.out_ready = 1'b1;
    checks++; if (k !== 4) begin errors++; $display("FAIL stall_timeout got=%0d exp=4", k); end
    checks++; if (bus_if.out_valid !== 1'b0) begin errors++; $display("FAIL stall_end_valid got=%b exp=0", bus_if.out_valid); end
    checks++; if (bus_if.rx_enable !== 1'b1) begin errors++; $display("FAIL stall_end_rx_enable got=%b exp=1", bus_if.rx_enable); end
  endtask

  task automatic test_back_to_back();
    int p0;
    do_reset();
    p0 = pulse_cnt;
    send_byte(8'h3C); send_byte(8'hA5, 1'b1); send_byte(8'h02);
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h44); send_byte(8'h55); send_byte(8'h13);
    collect_burst();
    checks++; if (cap_n !== 2 || cap_data[0] !== 8'h44 || cap_data[1] !== 8'h55) begin errors++; $display("FAIL b2b_first got_n=%0d d0=%h d1=%h exp=44,55", cap_n, cap_data[0], cap_data[1]); end
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h9C); send_byte(8'h9D);
    collect_burst();
    checks++; if (cap_n !== 1 || cap_data[0] !== 8'h9C || cap_last[0] !== 1'b1) begin errors++; $display("FAIL b2b_second got_n=%0d d0=%h exp=9c", cap_n, cap_data[0]); end
    checks++; if (bus_if.err_cnt !== 8'd0 || pulse_cnt !== p0) begin errors++; $display("FAIL b2b_no_err cnt=%0d pulses=%0d exp=0", bus_if.err_cnt, pulse_cnt - p0); end
  endtask

  task automatic test_rx_glitch();
    int p0;
    @(negedge clk);
    rst = 1'b1;
    bus_if.rx_done = 1'b0; bus_if.rx_data = 8'hA5; bus_if.rx_error = 1'b0; bus_if.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    bus_if.rx_done = 1'b1;
    repeat (3) @(negedge clk);
    p0 = pulse_cnt;
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h29); send_byte(8'h28);
    collect_burst();
    checks++; if (cap_n !== 1 || cap_data[0] !== 8'h29) begin errors++; $display("FAIL glitch_packet got_n=%0d d0=%h exp=29", cap_n, cap_data[0]); end
    checks++; if (bus_if.err_cnt !== 8'd0 || pulse_cnt !== p0) begin errors++; $display("FAIL glitch_no_err cnt=%0d pulses=%0d exp=0", bus_if.err_cnt, pulse_cnt - p0); end
  endtask

  task automatic test_parity_and_rst();
    int p0;
    do_reset();
    send_byte(8'hA5); send_byte(8'h00);
    send_byte(8'hA5); send_byte(8'h03); send_byte(8'hAA); send_byte(8'hBB, 1'b1);
    checks++; if (bus_if.pkt_err !== 1'b1) begin errors++; $display("FAIL parity_pkt_err got=%b exp=1", bus_if.pkt_err); end
    checks++; if (bus_if.err_code !== 2'd0) begin errors++; $display("FAIL parity_err_code got=%0d exp=0", bus_if.err_code); end
    checks++; if (bus_if.err_cnt !== 8'd2) begin errors++; $display("FAIL parity_err_cnt got=%0d exp=2", bus_if.err_cnt); end
    send_byte(8'hA5); send_byte(8'h03); send_byte(8'hAA);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    p0 = pulse_cnt;
    checks++; if (bus_if.err_cnt !== 8'd0) begin errors++; $display("FAIL rst_err_cnt got=%0d exp=0", bus_if.err_cnt); end
    send_byte(8'hCC); send_byte(8'hDD);
    checks++; if (bus_if.out_valid !== 1'b0) begin errors++; $display("FAIL rst_no_output got=%b exp=0", bus_if.out_valid); end
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h77); send_byte(8'h76);
    collect_burst();
    checks++; if (cap_n !== 1 || cap_data[0] !== 8'h77) begin errors++; $display("FAIL rst_recover got_n=%0d d0=%h exp=77", cap_n, cap_data[0]); end
    checks++; if (bus_if.err_cnt !== 8'd0 || pulse_cnt !== p0) begin errors++; $display("FAIL rst_no_err cnt=%0d pulses=%0d exp=0", bus_if.err_cnt, pulse_cnt - p0); end
  endtask

  initial begin
    bus_if.rx_done   = 1'b1;
    bus_if.rx_error  = 1'b0;
    bus_if.rx_data   = 8'h00;
    bus_if.out_ready = 1'b1;
    test_reset();
    test_basic();
    test_checksum();
    test_bad_len();
    test_timeout();
    test_stall();
    test_back_to_back();
    test_rx_glitch();
    test_parity_and_rst();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
